// File: rtl/gbuf_pkg.sv
// rtl/gbuf_pkg.sv - shared types and constants for the banked global buffer
// Purpose: burst-engine state encoding and the read-ahead occupancy limit.
// Ports: none (package).
package gbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } gbuf_state_e;

  // Reads in flight plus beats parked in the output buffer never exceed this.
  localparam int unsigned OCC_LIMIT = 2;

endpackage

// File: rtl/gbuf_skid_fifo.sv
// rtl/gbuf_skid_fifo.sv - two-entry output buffer holding beats under backpressure
// Purpose: decouples the registered RAM read from the consumer handshake.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_tvalid_i        beat offered by the read pipeline
//   s_tdata_i         beat payload ({last, data})
//   m_tvalid_o        head entry valid
//   m_tready_i        consumer accepts head entry
//   m_tdata_o         head entry payload, stable until accepted
//   count_o           current number of stored entries (0..2)
module gbuf_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tvalid_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] ent_q [2];
  logic             wp_q, rp_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign pop  = m_tvalid_o && m_tready_i;
  // Upstream keeps occupancy in check; the guard only protects against misuse.
  assign push = s_tvalid_i && ((cnt_q != 2'd2) || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        ent_q[wp_q] <= s_tdata_i;
        wp_q        <= ~wp_q;
      end
      if (pop) begin
        rp_q <= ~rp_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign m_tvalid_o = (cnt_q != 2'd0);
  assign m_tdata_o  = ent_q[rp_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/banked_global_buffer.sv
// rtl/banked_global_buffer.sv - byte-maskable word RAM with a streaming burst-read engine
// Purpose: single-port-write RAM plus a burst reader feeding a 2-entry output buffer.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_be write port with per-byte lane enables
//   rd_start/rd_base/rd_len     burst request (ignored while busy or when len is 0)
//   rd_busy                     burst engine active (RUN or DRAIN)
//   out_valid/out_ready         beat handshake
//   out_data/out_last           beat payload and end-of-burst marker
module banked_global_buffer
  import gbuf_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic [DATA_BITS/8-1:0] wr_be,
  input  logic                   rd_start,
  input  logic [ADDR_BITS-1:0]   rd_base,
  input  logic [ADDR_BITS:0]     rd_len,
  output logic                   rd_busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_BITS-1:0]   out_data,
  output logic                   out_last
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int LANES = DATA_BITS / 8;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] rd_data_q;

  gbuf_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [ADDR_BITS:0]   rem_q, rem_d;
  logic                 rd_vld_q, rd_last_q;
  logic [1:0]           fifo_cnt;
  logic [2:0]           occ;
  logic                 issue, pop;

  assign pop = out_valid && out_ready;

  // A read is in flight for exactly one cycle, so rd_vld_q is the in-flight count.
  // Counting occupancy after this cycle's pop lets a read issue every cycle while
  // the consumer drains, yet still never overfills the output buffer.
  assign occ   = 3'(rd_vld_q) + 3'(fifo_cnt) - 3'(pop);
  assign issue = (state_q == ST_RUN) && (occ < 3'(OCC_LIMIT));

  // RAM: no reset on contents; read-first behaviour falls out of the NBA ordering.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
    if (issue) begin
      rd_data_q <= mem_q[ptr_q];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_start && (rd_len != '0)) begin
          ptr_d   = rd_base;
          rem_d   = rd_len;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (ADDR_BITS+1)'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      rd_vld_q  <= issue;
      rd_last_q <= issue && (rem_q == (ADDR_BITS+1)'(1));
    end
  end

  assign rd_busy = (state_q != ST_IDLE);

  gbuf_skid_fifo #(
    .WIDTH (DATA_BITS + 1)
  ) u_out_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tvalid_i (rd_vld_q),
    .s_tdata_i  ({rd_last_q, rd_data_q}),
    .m_tvalid_o (out_valid),
    .m_tready_i (out_ready),
    .m_tdata_o  ({out_last, out_data}),
    .count_o    (fifo_cnt)
  );

endmodule

// File: tb/tb_banked_global_buffer.sv
// tb/tb_banked_global_buffer.sv - scoreboard bench for banked_global_buffer
module tb_banked_global_buffer;

  localparam int AB = 3;
  localparam int DB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AB-1:0] wr_addr = '0;
  logic [DB-1:0] wr_data = '0;
  logic [3:0]    wr_be = '0;
  logic          rd_start = 1'b0;
  logic [AB-1:0] rd_base = '0;
  logic [AB:0]   rd_len = '0;
  logic          rd_busy;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DB-1:0] out_data;
  logic          out_last;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DB:0] exp_q [$];

  always #5 clk = ~clk;

  banked_global_buffer #(
    .ADDR_BITS (AB),
    .DATA_BITS (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_start  (rd_start),
    .rd_base   (rd_base),
    .rd_len    (rd_len),
    .rd_busy   (rd_busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every accepted beat against the scoreboard and checks
  // that a stalled beat stays put until it is taken.
  logic        held_v = 1'b0;
  logic [DB:0] held   = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        n_tests++;
        if (!out_valid || ({out_last, out_data} !== held)) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b 0x%0h, expected v=1 0x%0h", out_valid, {out_last, out_data}, held);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: got 0x%0h, expected no beat", {out_last, out_data});
        end else begin
          logic [DB:0] e;
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_fail++;
            $display("FAIL beat: got last=%0b data=0x%0h, expected last=%0b data=0x%0h",
                     out_last, out_data, e[DB], e[DB-1:0]);
          end
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_last, out_data};
    end
  end

  task automatic wr(input int addr, input logic [DB-1:0] data, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = addr[AB-1:0]; wr_data = data; wr_be = be;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start(input int base, input int len);
    rd_start = 1'b1; rd_base = base[AB-1:0]; rd_len = len[AB:0];
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int k = 0;
    while ((rd_busy || exp_q.size() != 0) && k < 200) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    check("idle_timeout", 64'(k < 200), 64'd1);
  endtask

  // Memory image after the same-cycle write test: addr 3 holds 0x55, others hold addr.
  function automatic logic [DB-1:0] img(input int a);
    int m;
    m = a % 8;
    return (m == 3) ? 32'h55 : 32'(m);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    check("rst_busy", 64'(rd_busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte-lane merge
    wr(5, 32'hAABBCCDD, 4'b1111);
    wr(5, 32'h11223344, 4'b0101);
    exp_q.push_back({1'b1, 32'hAA22CC44});
    start(5, 1);
    wait_idle(0);

    // Wrap-around burst, latency and throughput
    for (int a = 0; a < 8; a++) wr(a, 32'(a), 4'b1111);
    exp_q.push_back({1'b0, 32'd6});
    exp_q.push_back({1'b0, 32'd7});
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b1, 32'd1});
    start(6, 4);
    check("lat_e0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_e1", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("tput_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_busy", 64'(rd_busy), 64'd0);
    check("post_sb", 64'(exp_q.size()), 64'd0);

    // Full burst under random backpressure
    for (int i = 0; i < 8; i++) exp_q.push_back({1'(i == 7), 32'(i)});
    start(0, 8);
    wait_idle(1);

    // Requests while busy and zero-length requests are ignored
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b1, 32'd2});
    start(0, 3);
    rd_start = 1'b1; rd_base = 3'd4; rd_len = 4'd5;
    @(posedge clk); #1;
    rd_start = 1'b0;
    check("busy_kept", 64'(rd_busy), 64'd1);
    wait_idle(0);
    start(2, 0);
    check("len0_busy", 64'(rd_busy), 64'd0);
    repeat (4) @(posedge clk); #1;
    check("len0_valid", 64'(out_valid), 64'd0);

    // Same-cycle write and read of one address returns old data
    wr(3, 32'h0, 4'b1111);
    exp_q.push_back({1'b1, 32'h0});
    rd_start = 1'b1; rd_base = 3'd3; rd_len = 4'd1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h55; wr_be = 4'b1111;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_idle(0);
    exp_q.push_back({1'b1, 32'h55});
    start(3, 1);
    wait_idle(0);

    // rd_len beyond DEPTH re-reads from the start
    for (int i = 0; i < 10; i++) exp_q.push_back({1'(i == 9), img(7 + i)});
    start(7, 10);
    wait_idle(0);

    // Reset mid-burst aborts it; memory survives
    for (int i = 0; i < 15; i++) exp_q.push_back({1'(i == 14), img(i)});
    start(0, 15);
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(rd_busy), 64'd0);
    check("abort_last", 64'(out_last), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("no_stale", 64'(out_valid), 64'd0);
    exp_q.push_back({1'b0, img(2)});
    exp_q.push_back({1'b0, img(3)});
    exp_q.push_back({1'b1, img(4)});
    start(2, 3);
    wait_idle(0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
